// File: rtl/project_pwm_trip_zone.sv
// project_pwm_trip_zone
//
// Trip-zone protection between the deadband outputs and the PWM pins. An external
// active-low fault pin is synchronized and glitch-filtered. An accepted fault forces
// every channel to a programmable safe level. Normal waveforms resume only on a
// period boundary (i_sync). This happens after a software clear in one-shot mode,
// or automatically in cycle-by-cycle mode.
//
// Ports
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_pwm[5:0]    post-deadband PWM, bit 0 = 1A ... bit 5 = 3B
//   i_trip_n      asynchronous active-low fault pin
//   i_mode        0 = one-shot latch, 1 = cycle-by-cycle
//   i_filter      extra consecutive low samples required before a fault is accepted
//   i_safe[5:0]   per-channel level forced while tripped
//   i_sync        one-cycle pulse at the period boundary
//   i_clear       one-cycle software clear request
//   o_pwm[5:0]    protected PWM (registered)
//   o_tripped     high whenever the protection is not armed (registered)
//   o_fault_flag  sticky fault status (registered)

module project_pwm_trip_zone #(
   parameter int unsigned FILTER_WIDTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [5:0]              i_pwm,
   input  logic                    i_trip_n,
   input  logic                    i_mode,
   input  logic [FILTER_WIDTH-1:0] i_filter,
   input  logic [5:0]              i_safe,
   input  logic                    i_sync,
   input  logic                    i_clear,
   output logic [5:0]              o_pwm,
   output logic                    o_tripped,
   output logic                    o_fault_flag
);

   typedef enum logic [1:0] {
      StArmed   = 2'd0,
      StTripped = 2'd1,
      StRelease = 2'd2
   } state_e;

   localparam logic [FILTER_WIDTH-1:0] CntMax = '1;
   localparam logic [FILTER_WIDTH-1:0] CntOne = FILTER_WIDTH'(1);

   // ---------------------------------------------------------------------------
   // Two-flop synchronizer. Both flops reset high, so reset reads as "no fault".
   // ---------------------------------------------------------------------------
   logic trip_meta_q;
   logic trip_sync_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         trip_meta_q <= 1'b1;
         trip_sync_q <= 1'b1;
      end else begin
         trip_meta_q <= i_trip_n;
         trip_sync_q <= trip_meta_q;
      end
   end

   logic fault_raw;
   assign fault_raw = ~trip_sync_q;

   // ---------------------------------------------------------------------------
   // Glitch filter. cnt_q counts earlier consecutive low samples. The current
   // sample is accepted once cnt_q has reached i_filter, so a fault is accepted
   // on the (i_filter + 1)-th consecutive low sample.
   // ---------------------------------------------------------------------------
   logic [FILTER_WIDTH-1:0] cnt_q;
   logic [FILTER_WIDTH-1:0] cnt_d;
   logic                    fault;

   always_comb begin
      cnt_d = '0;
      if (fault_raw) begin
         cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fault = fault_raw & (cnt_q >= i_filter);

   // ---------------------------------------------------------------------------
   // Protection state machine
   // ---------------------------------------------------------------------------
   state_e state_q;
   state_e state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StArmed: begin
            if (fault) begin
               state_d = StTripped;
            end
         end
         StTripped: begin
            // i_mode is used live, so a mode switch mid-trip acts on this edge.
            if (!fault && (i_mode || i_clear)) begin
               state_d = StRelease;
            end
         end
         StRelease: begin
            // A fault outranks a coincident period boundary.
            if (fault) begin
               state_d = StTripped;
            end else if (i_sync) begin
               state_d = StArmed;
            end
         end
         default: begin
            state_d = StArmed;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= StArmed;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs. They are decoded from the next state so that a trip
   // reaches the pins on the same edge the state machine enters TRIPPED.
   // ---------------------------------------------------------------------------
   logic [5:0] pwm_q;
   logic [5:0] pwm_d;
   logic       tripped_q;
   logic       tripped_d;
   logic       flag_q;
   logic       flag_d;

   always_comb begin
      pwm_d     = (state_d == StArmed) ? i_pwm : i_safe;
      tripped_d = (state_d != StArmed);
      flag_d    = flag_q;
      // Set outranks clear.
      if (fault) begin
         flag_d = 1'b1;
      end else if (i_clear) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pwm_q     <= 6'b000000;
         tripped_q <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         pwm_q     <= pwm_d;
         tripped_q <= tripped_d;
         flag_q    <= flag_d;
      end
   end

   assign o_pwm        = pwm_q;
   assign o_tripped    = tripped_q;
   assign o_fault_flag = flag_q;

endmodule
